// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file defaults shared by decode, writeback and the register file
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_DEPTH    = 32;
  localparam bit DEFAULT_ZERO_REG = 1'b1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for results still in flight
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter bit ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_enable,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic              busy1,
  output logic              busy2
);

  logic [DEPTH-1:0] busy;

  // A reserve beats a same-edge release: the new producer claims the register
  // after the old result lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG && i == 0)
          busy[i] <= 1'b0;
        else if (rsv_enable && rsv_addr == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (w_enable && w_addr == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy1 = busy[r_addr1] & ~(w_enable && w_addr == r_addr1);
  assign busy2 = busy[r_addr2] & ~(w_enable && w_addr == r_addr2);

endmodule

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2-read/1-write register file with bypass, zero register and busy scoreboard
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_w(DEPTH),
  parameter bit ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_enable,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              r_valid,
  input  logic              rsv_enable,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_ok = w_enable && !(ZERO_REG && w_addr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_ok) begin
      mem[w_addr] <= w_data;
    end
  end

  // Bypass first, then the zero register overrides it.
  always_comb begin
    rd1 = mem[r_addr1];
    rd2 = mem[r_addr2];
    if (wr_ok && w_addr == r_addr1) rd1 = w_data;
    if (wr_ok && w_addr == r_addr2) rd2 = w_data;
    if (ZERO_REG && r_addr1 == '0) rd1 = '0;
    if (ZERO_REG && r_addr2 == '0) rd2 = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data1 <= '0;
      out_data2 <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= r_enable;
      if (r_enable) begin
        out_data1 <= rd1;
        out_data2 <= rd2;
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_enable (rsv_enable),
    .rsv_addr   (rsv_addr),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .r_addr1    (r_addr1),
    .r_addr2    (r_addr2),
    .busy1      (busy1),
    .busy2      (busy2)
  );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb/tb_regfile_2r1w_sb.sv - directed table-driven bench for regfile_2r1w_sb
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_enable, r_enable, rsv_enable;
  logic [4:0]  w_addr, r_addr1, r_addr2, rsv_addr;
  logic [31:0] w_data;
  logic [31:0] out_data1, out_data2, nz_data1, nz_data2;
  logic        r_valid, busy1, busy2, nz_valid, nz_busy1, nz_busy2;

  logic        x_w_enable, x_r_enable, x_rsv_enable;
  logic [2:0]  x_w_addr, x_r_addr1, x_r_addr2, x_rsv_addr;
  logic [63:0] x_w_data, x_data1, x_data2;
  logic        x_valid, x_busy1, x_busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w_sb u_dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .r_enable(r_enable), .r_addr1(r_addr1), .r_addr2(r_addr2),
    .out_data1(out_data1), .out_data2(out_data2), .r_valid(r_valid),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2)
  );

  regfile_2r1w_sb #(.ZERO_REG(1'b0)) u_dut_nz (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .r_enable(r_enable), .r_addr1(r_addr1), .r_addr2(r_addr2),
    .out_data1(nz_data1), .out_data2(nz_data2), .r_valid(nz_valid),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .busy1(nz_busy1), .busy2(nz_busy2)
  );

  regfile_2r1w_sb #(.DATA_W(64), .DEPTH(8)) u_dut_w (
    .clk(clk), .rst(rst), .w_enable(x_w_enable), .w_addr(x_w_addr), .w_data(x_w_data),
    .r_enable(x_r_enable), .r_addr1(x_r_addr1), .r_addr2(x_r_addr2),
    .out_data1(x_data1), .out_data2(x_data2), .r_valid(x_valid),
    .rsv_enable(x_rsv_enable), .rsv_addr(x_rsv_addr), .busy1(x_busy1), .busy2(x_busy2)
  );

  typedef struct {
    logic        w_en;
    logic [4:0]  w_a;
    logic [31:0] w_d;
    logic        r_en;
    logic [4:0]  r_a1;
    logic [4:0]  r_a2;
    logic        rsv_en;
    logic [4:0]  rsv_a;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_v;
    logic [31:0] e_nz1;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re, input logic [4:0] a1, input logic [4:0] a2,
                              input logic se, input logic [4:0] sa, input logic b1, input logic b2,
                              input logic [31:0] d1, input logic [31:0] d2, input logic v,
                              input logic [31:0] nz1);
    vec_t t;
    t.w_en = we; t.w_a = wa; t.w_d = wd; t.r_en = re; t.r_a1 = a1; t.r_a2 = a2;
    t.rsv_en = se; t.rsv_a = sa; t.e_b1 = b1; t.e_b2 = b2; t.e_d1 = d1; t.e_d2 = d2;
    t.e_v = v; t.e_nz1 = nz1;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    w_enable = 0; w_addr = 0; w_data = 0; r_enable = 0; r_addr1 = 0; r_addr2 = 0;
    rsv_enable = 0; rsv_addr = 0;
  endtask

  initial begin
    //                we wa  wd    re a1  a2  se sa  b1 b2 d1    d2    v  nz1
    vecs[0]  = mk(1, 10, 1000, 0, 0,  0,  0, 0,  0, 0, 0,    0,    0, 0);
    vecs[1]  = mk(1, 20, 2000, 0, 0,  0,  0, 0,  0, 0, 0,    0,    0, 0);
    vecs[2]  = mk(0, 0,  0,    1, 10, 20, 0, 0,  0, 0, 1000, 2000, 1, 1000);
    vecs[3]  = mk(0, 0,  0,    0, 10, 20, 0, 0,  0, 0, 1000, 2000, 0, 1000);
    vecs[4]  = mk(1, 15, 3000, 0, 10, 20, 0, 0,  0, 0, 1000, 2000, 0, 1000);
    vecs[5]  = mk(1, 15, 4000, 1, 15, 15, 0, 0,  0, 0, 4000, 4000, 1, 4000);
    vecs[6]  = mk(0, 0,  0,    1, 15, 15, 0, 0,  0, 0, 4000, 4000, 1, 4000);
    vecs[7]  = mk(1, 0,  6000, 1, 0,  20, 1, 0,  0, 0, 0,    2000, 1, 6000);
    vecs[8]  = mk(0, 0,  0,    1, 0,  0,  1, 0,  0, 0, 0,    0,    1, 6000);
    vecs[9]  = mk(0, 0,  0,    0, 30, 10, 1, 30, 0, 0, 0,    0,    0, 6000);
    vecs[10] = mk(1, 30, 7,    1, 30, 10, 0, 0,  0, 0, 7,    1000, 1, 7);
    vecs[11] = mk(0, 0,  0,    0, 30, 10, 0, 0,  0, 0, 7,    1000, 0, 7);
    vecs[12] = mk(1, 30, 8,    0, 30, 10, 1, 30, 0, 0, 7,    1000, 0, 7);
    vecs[13] = mk(0, 0,  0,    0, 30, 30, 0, 0,  1, 1, 7,    1000, 0, 7);
    vecs[14] = mk(1, 30, 9,    1, 30, 10, 0, 0,  0, 0, 9,    1000, 1, 9);
    vecs[15] = mk(0, 0,  0,    0, 30, 30, 0, 0,  0, 0, 9,    1000, 0, 9);

    idle_inputs();
    x_w_enable = 0; x_w_addr = 0; x_w_data = 0; x_r_enable = 0; x_r_addr1 = 0;
    x_r_addr2 = 0; x_rsv_enable = 0; x_rsv_addr = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_data1", 64'(out_data1), 0);
    chk("reset out_data2", 64'(out_data2), 0);
    chk("reset r_valid", 64'(r_valid), 0);
    chk("reset busy1", 64'(busy1), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      w_enable = vecs[i].w_en; w_addr = vecs[i].w_a; w_data = vecs[i].w_d;
      r_enable = vecs[i].r_en; r_addr1 = vecs[i].r_a1; r_addr2 = vecs[i].r_a2;
      rsv_enable = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_a;
      #1;
      chk($sformatf("row%0d busy1", i), 64'(busy1), 64'(vecs[i].e_b1));
      chk($sformatf("row%0d busy2", i), 64'(busy2), 64'(vecs[i].e_b2));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_data1", i), 64'(out_data1), 64'(vecs[i].e_d1));
      chk($sformatf("row%0d out_data2", i), 64'(out_data2), 64'(vecs[i].e_d2));
      chk($sformatf("row%0d r_valid", i), 64'(r_valid), 64'(vecs[i].e_v));
      chk($sformatf("row%0d nz out_data1", i), 64'(nz_data1), 64'(vecs[i].e_nz1));
    end

    // Wide, shallow instance: exact 64-bit readback, then hold across a later write.
    @(negedge clk);
    idle_inputs();
    x_w_enable = 1; x_w_addr = 7; x_w_data = 64'hFFFF_0000_1234_5678;
    @(negedge clk);
    x_w_enable = 0; x_r_enable = 1; x_r_addr1 = 7; x_r_addr2 = 7;
    @(posedge clk);
    #1;
    chk("wide out_data1", x_data1, 64'hFFFF_0000_1234_5678);
    chk("wide out_data2", x_data2, 64'hFFFF_0000_1234_5678);
    chk("wide r_valid", 64'(x_valid), 1);
    @(negedge clk);
    x_r_enable = 0; x_w_enable = 1; x_w_data = 64'h1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("wide hold%0d data1", c), x_data1, 64'hFFFF_0000_1234_5678);
      chk($sformatf("wide hold%0d r_valid", c), 64'(x_valid), 0);
      @(negedge clk);
      x_w_enable = 0;
    end

    // Mid-run reset drops a pending read result and every reservation.
    rsv_enable = 1; rsv_addr = 10; r_enable = 1; r_addr1 = 10; r_addr2 = 20;
    @(posedge clk);
    #2;
    rsv_enable = 0; r_enable = 0;
    #1;
    chk("pre-reset busy1", 64'(busy1), 1);
    chk("pre-reset r_valid", 64'(r_valid), 1);
    chk("pre-reset out_data1", 64'(out_data1), 1000);
    rst = 1'b0;
    #1;
    chk("mid reset out_data1", 64'(out_data1), 0);
    chk("mid reset out_data2", 64'(out_data2), 0);
    chk("mid reset r_valid", 64'(r_valid), 0);
    chk("mid reset busy1", 64'(busy1), 0);
    chk("mid reset wide data1", x_data1, 0);
    @(negedge clk);
    rst = 1'b1;
    r_enable = 1; r_addr1 = 10; r_addr2 = 20;
    @(posedge clk);
    #1;
    chk("post-reset reg10", 64'(out_data1), 0);
    chk("post-reset reg20", 64'(out_data2), 0);
    chk("post-reset r_valid", 64'(r_valid), 1);
    @(negedge clk);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
